// File: rtl/pulse_coalesce.sv
// pulse_coalesce: counts single-cycle event pulses from the pulse synchronizer
// and releases them as one count record per burst on a valid/ready handshake.
// A record is cut when the pending count reaches the threshold or when the
// holdoff timer expires; pulses arriving while a record waits are kept.
module pulse_coalesce #(
    parameter int WIDTH     = 8,
    parameter int TMR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 i,
    input  logic [WIDTH-1:0]     thresh,
    input  logic [TMR_WIDTH-1:0] holdoff,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [WIDTH-1:0]     o_count,
    output logic                 o_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]     ACC_MAX = '1;
    localparam logic [WIDTH-1:0]     ACC_ONE = WIDTH'(1);
    localparam logic [TMR_WIDTH-1:0] TMR_ONE = TMR_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_acc;
    logic                   r_ovf;
    logic [TMR_WIDTH-1:0]   r_timer;
    logic                   r_valid;
    logic [WIDTH-1:0]       r_count;
    logic                   r_count_ovf;

    logic [WIDTH-1:0]       w_acc_nxt;
    logic                   w_ovf_nxt;
    logic [WIDTH-1:0]       w_thresh_eff;
    logic                   w_timeout;
    logic                   w_flush;
    logic                   w_accept;
    logic                   w_capture;

    // Saturating accumulate; the sticky flag records a pulse lost at the ceiling.
    assign w_acc_nxt    = (i && (r_acc != ACC_MAX)) ? r_acc + ACC_ONE : r_acc;
    assign w_ovf_nxt    = r_ovf | (i & (r_acc == ACC_MAX));

    // A zero threshold would never be "reached" meaningfully, so it acts as 1.
    assign w_thresh_eff = (thresh == '0) ? ACC_ONE : thresh;
    assign w_timeout    = (holdoff != '0) && (r_timer == holdoff) && (r_acc != '0);
    assign w_flush      = (w_acc_nxt >= w_thresh_eff) || w_timeout;
    assign w_accept     = r_valid & o_ready;

    // Next-state decode: decides when a pending batch is captured into a record.
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i) begin
                    w_state_nxt = w_flush ? ST_SEND : ST_ACCUM;
                    w_capture   = w_flush;
                end
            end
            ST_ACCUM: begin
                if (w_flush) begin
                    w_state_nxt = ST_SEND;
                    w_capture   = 1'b1;
                end
            end
            ST_SEND: begin
                // Events that arrived while presenting decide where we resume;
                // a capture is never taken here, so a new record needs one ACCUM cycle.
                if (w_accept) begin
                    w_state_nxt = (w_acc_nxt == '0) ? ST_IDLE : ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending batch: accumulator, sticky saturation flag and holdoff timer.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_timer <= '0;
        end else if (w_capture) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
            // The timer counts cycles since the first pending event; it holds
            // at zero while nothing is pending and saturates at the holdoff.
            if (r_acc == '0) begin
                r_timer <= '0;
            end else if (r_timer < holdoff) begin
                r_timer <= r_timer + TMR_ONE;
            end
        end
    end

    // Presented record: loaded on capture, held until the consumer accepts it.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_valid     <= 1'b0;
            r_count     <= '0;
            r_count_ovf <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_count     <= w_acc_nxt;
            r_count_ovf <= w_ovf_nxt;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_ovf   = r_count_ovf;

endmodule

// File: tb/tb_pulse_coalesce.sv
// tb_pulse_coalesce: directed scenarios plus randomized traffic, checked every
// cycle against an event-level reference model of the coalescer.
module tb_pulse_coalesce;

    localparam int W       = 8;
    localparam int TW      = 8;
    localparam int CNT_MAX = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset_l;
    logic          i;
    logic [W-1:0]  thresh;
    logic [TW-1:0] holdoff;
    logic          o_valid;
    logic          o_ready;
    logic [W-1:0]  o_count;
    logic          o_ovf;

    pulse_coalesce #(.WIDTH(W), .TMR_WIDTH(TW)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .i       (i),
        .thresh  (thresh),
        .holdoff (holdoff),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_count (o_count),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw number of uncaptured events (unbounded), the cycle
    // the current batch began, and the record currently offered.
    int m_raw   = 0;
    int m_first = 0;
    int m_cyc   = 0;
    bit m_valid = 1'b0;
    int m_cnt   = 0;
    bit m_ovf   = 1'b0;

    // Records actually handed over by the DUT, logged on accepting cycles.
    int rec_cnt[$];
    int rec_ovf[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of the reference model, using the inputs driven for this cycle.
    task automatic model_step();
        int  raw_n;
        int  cnt_n;
        int  thr;
        bit  timeout;
        bit  flush;
        raw_n   = m_raw + int'(i);
        cnt_n   = (raw_n > CNT_MAX) ? CNT_MAX : raw_n;
        thr     = (thresh == 0) ? 1 : int'(thresh);
        timeout = (holdoff != 0) && (m_raw > 0) && ((m_cyc - m_first - 1) >= int'(holdoff));
        flush   = (cnt_n >= thr) || timeout;
        if (!m_valid && flush) begin
            m_valid = 1'b1;
            m_cnt   = cnt_n;
            m_ovf   = (raw_n > CNT_MAX);
            m_raw   = 0;
        end else begin
            if (m_raw == 0 && i) m_first = m_cyc;
            m_raw = raw_n;
            if (m_valid && o_ready) m_valid = 1'b0;
        end
        m_cyc++;
    endtask

    task automatic cycle(input bit pi, input bit prdy);
        @(negedge clk);
        check("valid", int'(o_valid), int'(m_valid));
        if (m_valid) begin
            check("count", int'(o_count), m_cnt);
            check("ovf", int'(o_ovf), int'(m_ovf));
        end
        i       = pi;
        o_ready = prdy;
        if (o_valid && prdy) begin
            rec_cnt.push_back(int'(o_count));
            rec_ovf.push_back(int'(o_ovf));
        end
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        i       = 1'b0;
        reset_l = 1'b0;
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_count", int'(o_count), 0);
        check("rst_ovf", int'(o_ovf), 0);
        m_raw   = 0;
        m_valid = 1'b0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
    endtask

    task automatic check_rec(input string tag, input int idx, input int cnt, input int ovf);
        check({tag, "_cnt"}, (idx < rec_cnt.size()) ? rec_cnt[idx] : -1, cnt);
        check({tag, "_ovf"}, (idx < rec_ovf.size()) ? rec_ovf[idx] : -1, ovf);
    endtask

    initial begin
        int base;
        reset_l = 1'b1;
        i       = 1'b0;
        o_ready = 1'b0;
        thresh  = W'(1);
        holdoff = '0;
        #2;
        do_reset();

        // Single pulse, threshold 1: record of 1 the next cycle, gone after accept.
        base = rec_cnt.size();
        cycle(1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1);
        check("t1_nrec", rec_cnt.size() - base, 1);
        check_rec("t1", base, 1, 0);

        // Threshold 4 with four back-to-back pulses: one record of 4.
        thresh = W'(4);
        base   = rec_cnt.size();
        repeat (4) cycle(1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1);
        check("t2_nrec", rec_cnt.size() - base, 1);
        check_rec("t2", base, 4, 0);

        // Timeout: two pulses, holdoff 5, threshold out of reach.
        thresh  = W'(100);
        holdoff = TW'(5);
        do_reset();
        base = rec_cnt.size();
        repeat (2) cycle(1'b1, 1'b1);
        repeat (10) cycle(1'b0, 1'b1);
        check("t3_nrec", rec_cnt.size() - base, 1);
        check_rec("t3", base, 2, 0);

        // Stalled record keeps its value; pulses during stall and on accept form the next.
        holdoff = '0;
        thresh  = W'(1);
        do_reset();
        base = rec_cnt.size();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1);
        check("t4_nrec", rec_cnt.size() - base, 2);
        check_rec("t4a", base, 1, 0);
        check_rec("t4b", base + 1, 3, 0);

        // 300 pulses at threshold 255 while stalled: 255 now, 45 held for later.
        thresh = W'(255);
        base   = rec_cnt.size();
        repeat (300) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        thresh = W'(1);
        repeat (4) cycle(1'b0, 1'b1);
        check("t5_nrec", rec_cnt.size() - base, 2);
        check_rec("t5a", base, 255, 0);
        check_rec("t5b", base + 1, 45, 0);

        // Stall long enough for the pending count to saturate: second record flags overflow.
        thresh = W'(255);
        base   = rec_cnt.size();
        repeat (255) cycle(1'b1, 1'b0);
        repeat (300) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b1);
        check("t6_nrec", rec_cnt.size() - base, 2);
        check_rec("t6a", base, 255, 0);
        check_rec("t6b", base + 1, 255, 1);

        // Reset while presenting a record: it is dropped and nothing follows.
        thresh = W'(1);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        #2;
        do_reset();
        base = rec_cnt.size();
        repeat (8) cycle(1'b0, 1'b1);
        check("t7_none", rec_cnt.size() - base, 0);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
        check("t7_nrec", rec_cnt.size() - base, 1);
        check_rec("t7", base, 1, 0);

        // Reset while accumulating: pending events discarded.
        thresh = W'(100);
        repeat (3) cycle(1'b1, 1'b1);
        #2;
        do_reset();
        base = rec_cnt.size();
        repeat (8) cycle(1'b0, 1'b1);
        check("t8_none", rec_cnt.size() - base, 0);
        thresh = W'(1);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
        check("t8_nrec", rec_cnt.size() - base, 1);
        check_rec("t8", base, 1, 0);

        // Randomized traffic under random thresholds, holdoffs and back-pressure.
        for (int t = 0; t < 10; t++) begin
            int p_i;
            int p_rdy;
            thresh  = W'($urandom_range(0, 7));
            holdoff = TW'($urandom_range(0, 6));
            p_i     = int'($urandom_range(20, 80));
            p_rdy   = int'($urandom_range(20, 90));
            do_reset();
            for (int c = 0; c < 400; c++) begin
                cycle($urandom_range(0, 99) < p_i, $urandom_range(0, 99) < p_rdy);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_coalesce.md
# pulse_coalesce

Single-clock event coalescer that sits directly downstream of the pulse synchronizer, in the destination clock domain. It counts the single-cycle event pulses that the synchronizer delivers and batches them into one count record. The record is released on a valid/ready handshake when a count threshold is reached or a holdoff timer expires, so software or a downstream FSM sees one record per burst instead of one per event. No pulse is lost across handoff.

## Interface
- WIDTH, 8: width of the event count (accumulator and o_count).
- TMR_WIDTH, 8: width of the holdoff timer and of the holdoff input.
- clk  input  1  clock; the same clock as the synchronizer's output side.
- reset_l  input  1  asynchronous active-low reset.
- i  input  1  event pulse; one event per cycle it is high.
- thresh  input  WIDTH  flush when pending count >= thresh; 0 is treated as 1; quasi-static.
- holdoff  input  TMR_WIDTH  flush after this many cycles of pending events; 0 disables the timeout; quasi-static.
- o_valid  output  1  record available.
- o_ready  input  1  consumer accepts the record when o_valid && o_ready.
- o_count  output  WIDTH  number of events in the record; held stable while o_valid is high.
- o_ovf  output  1  pending count saturated before capture; held stable with o_count.

## Operation
- Internal state:
  - acc (WIDTH): pending count.
  - ovf: sticky saturation flag.
  - timer (TMR_WIDTH).
  - state: IDLE, ACCUM or SEND.
- acc_nxt = acc + i, saturating at 2^WIDTH-1. ovf_nxt = ovf | (i && acc == max).
- timer:
  - Loads 0 on the cycle acc goes from 0 to nonzero.
  - Otherwise increments each cycle that acc != 0, saturating at holdoff.
  - Cleared when acc is cleared.
- flush = (acc_nxt >= max(thresh,1)) || (holdoff != 0 && timer == holdoff && acc != 0).
- IDLE (acc == 0):
  - i with flush → SEND.
  - i without flush → ACCUM.
  - No i → stay.
- ACCUM:
  - flush → SEND.
  - Otherwise accumulate.
- Entry to SEND: o_count <= acc_nxt, o_ovf <= ovf_nxt, acc <= 0, ovf <= 0, timer <= 0, o_valid <= 1.
- SEND:
  - Pulses keep accumulating into acc from 0 and the timer runs. No second capture occurs while o_valid is high.
  - On handshake: o_valid <= 0. Next state is IDLE if acc_nxt == 0, else ACCUM.
  - If the ACCUM flush condition already holds after the handshake, SEND is re-entered on the next cycle.
- Reset mid-operation: all pending and presented events are discarded and no record is emitted.

## Timing
- Reset values: o_valid 0, o_count 0, o_ovf 0; state IDLE, acc 0, timer 0.
- All outputs are registered; no combinational path from i or o_ready to any output.
- Latency, for a pulse in cycle N from IDLE:
  - thresh <= 1: o_valid is high in cycle N+1.
  - Timeout, holdoff = H and the threshold not met: o_valid rises in cycle N+H+2.
- Handshake: o_valid is not deasserted and o_count/o_ovf do not change until the accepting cycle. o_valid low the cycle after acceptance.
- Simultaneous events:
  - Pulse in the capture cycle: included in o_count.
  - Pulse in the accept cycle: retained in acc, never dropped.
- Back-to-back records: minimum 2 cycles between accepts (SEND → ACCUM → SEND).
- thresh/holdoff changes take effect on the next flush evaluation; no glitch protection is required.

## Structure
- Single module. No shared package: state encoding is local to the module.
- Natural sub-module: none; the saturating accumulator and timer stay inline.
- Typical integration: pulse_sync output → i of pulse_coalesce, both in the o_clk domain.

## Test plan
- Reset, then one pulse with thresh=1, holdoff=0, o_ready=1 → o_valid for exactly 1 cycle at N+1, o_count=1, o_ovf=0.
- thresh=4, holdoff=0, pulses in 4 consecutive cycles → single record, o_count=4, o_valid rises the cycle after the 4th pulse.
- thresh=100, holdoff=5, 2 pulses at N and N+1 → o_valid at N+7, o_count=2.
- o_ready=0 while presenting a record, 3 more pulses arrive including one on the accept cycle → o_count stays at the first value until accepted; the next record has o_count=3.
- WIDTH=8, thresh=0xFF, holdoff=0, o_ready=0, 300 pulses → first record o_count=255, o_ovf=0. Remaining 45 pulses are held in acc until acceptance, then flush as a second record with o_count=45, o_ovf=0. Repeat with the first record stalled until acc saturates → later record o_count=255, o_ovf=1.
- Assert reset_l low while in SEND and ACCUM → o_valid drops immediately, no record emitted after release, next single pulse yields o_count=1.
